// File: rtl/lm_sm_sequencer_if.sv
// Register-file and data-memory port bundle driven by the LM/SM sequencer.
// The master side is the sequencer; the slave side is regfile plus memory.
interface lm_sm_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic [2:0]        reg_read_addr;
  logic [DATA_W-1:0] reg_read_data;
  logic              reg_write_en;
  logic [2:0]        reg_write_dest;
  logic [DATA_W-1:0] reg_write_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output reg_read_addr, reg_write_en, reg_write_dest, reg_write_data,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  reg_read_data, mem_rdata, mem_ready
  );

  modport slave (
    input  reg_read_addr, reg_write_en, reg_write_dest, reg_write_data,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output reg_read_data, mem_rdata, mem_ready
  );
endinterface

// File: rtl/lm_sm_sequencer.sv
// Load/store-multiple sequencer: walks an 8-bit register mask R0..R7, one memory
// beat per cycle, holding the PC until the transfer finishes or times out.
module lm_sm_sequencer #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        reg_mask,
  lm_sm_sequencer_if.master bus,
  output logic              busy,
  output logic              pc_hold,
  output logic              done,
  output logic              err,
  output logic [3:0]        xfer_count
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, state_nxt;
  logic [7:0]        rem_mask;
  logic [ADDR_W-1:0] addr_ptr;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_q;
  logic              abort_q;
  logic [2:0]        cur_reg;
  logic [7:0]        clr_mask;
  logic              beat;
  logic              timeout_hit;

  // Lowest set bit wins, so R0 is always transferred first.
  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_set = 3'(i);
    end
  endfunction

  assign cur_reg     = lowest_set(rem_mask);
  assign clr_mask    = rem_mask & ~(8'd1 << cur_reg);
  assign beat        = (state == ACCESS) && bus.mem_ready;
  assign timeout_hit = (TIMEOUT != 0) && (state == ACCESS) && !bus.mem_ready &&
                       (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (reg_mask == 8'd0) ? DONE : ACCESS;
      ACCESS:  if ((beat && clr_mask == 8'd0) || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_mask   <= 8'd0;
      addr_ptr   <= '0;
      xfer_count <= 4'd0;
      wait_cnt   <= '0;
      load_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else if (state == IDLE && start) begin
      rem_mask   <= reg_mask;
      addr_ptr   <= base_addr;
      xfer_count <= 4'd0;
      wait_cnt   <= '0;
      load_q     <= is_load;
      abort_q    <= 1'b0;
    end else if (state == ACCESS) begin
      if (beat) begin
        rem_mask   <= clr_mask;
        addr_ptr   <= addr_ptr + 1'b1;
        xfer_count <= xfer_count + 4'd1;
        wait_cnt   <= '0;
      end else if (timeout_hit) begin
        abort_q  <= 1'b1;
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // A stalled beat keeps every output at its current value; only wait_cnt moves.
  always_comb begin
    bus.reg_read_addr  = 3'd0;
    bus.reg_write_en   = 1'b0;
    bus.reg_write_dest = 3'd0;
    bus.reg_write_data = '0;
    bus.mem_req        = 1'b0;
    bus.mem_we         = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_wdata      = '0;
    busy               = (state == ACCESS) || (state == DONE);
    done               = (state == DONE);
    err                = (state == DONE) && abort_q;
    if (state == ACCESS) begin
      bus.mem_req       = 1'b1;
      bus.mem_we        = ~load_q;
      bus.mem_addr      = addr_ptr;
      bus.reg_read_addr = cur_reg;
      if (!load_q) bus.mem_wdata = bus.reg_read_data;
      if (load_q && bus.mem_ready) begin
        bus.reg_write_en   = 1'b1;
        bus.reg_write_dest = cur_reg;
        bus.reg_write_data = bus.mem_rdata;
      end
    end
  end

  assign pc_hold = busy;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Bench for lm_sm_sequencer: environment regfile/memory plus an expected-state model
// derived from the transfer rules (beat k moves R[k-th set bit] <-> M[base+k]).
module tb_lm_sm_sequencer;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              is_load;
  logic [ADDR_W-1:0] base_addr;
  logic [7:0]        reg_mask;
  logic              mem_ready;
  logic              busy, pc_hold, done, err;
  logic [3:0]        xfer_count;

  logic [DATA_W-1:0] mem     [0:65535];
  logic [DATA_W-1:0] exp_mem [0:65535];
  logic [DATA_W-1:0] rf      [0:7];
  logic [DATA_W-1:0] exp_rf  [0:7];

  int vectors;
  int miscompares;

  lm_sm_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  assign bus.mem_ready     = mem_ready;
  assign bus.mem_rdata     = mem[bus.mem_addr];
  assign bus.reg_read_data = rf[bus.reg_read_addr];

  lm_sm_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_load    (is_load),
    .base_addr  (base_addr),
    .reg_mask   (reg_mask),
    .bus        (bus),
    .busy       (busy),
    .pc_hold    (pc_hold),
    .done       (done),
    .err        (err),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One LM/SM operation. stall_beat>=0 forces stall_len low cycles on that beat;
  // otherwise mem_ready is low with probability low_pct. rst_at>=1 resets after that many beats.
  task automatic run_op(input bit ld, input logic [15:0] base, input logic [7:0] mask,
                        input int low_pct, input int stall_beat, input int stall_len,
                        input int rst_at);
    logic [2:0]  q[$];
    logic [15:0] a;
    logic [2:0]  w_dest;
    logic [15:0] w_addr, w_data, r_data;
    int          n, k, waits;
    bit          aborted, finished, rdy, w_rf, w_mem, do_rst;
    for (int i = 0; i < 8; i++) if (mask[i]) q.push_back(3'(i));
    n = q.size(); k = 0; waits = 0; aborted = 0; finished = 0; do_rst = 0;

    @(negedge clk);
    start = 1'b1; is_load = ld; base_addr = base; reg_mask = mask; mem_ready = 1'b0;
    #1;
    chk("idle_busy", 32'(busy), 32'(0));
    chk("idle_req", 32'(bus.mem_req), 32'(0));
    @(posedge clk);

    for (int cyc = 0; cyc < 200 && !finished && !do_rst; cyc++) begin
      @(negedge clk);
      start = 1'($urandom); is_load = 1'($urandom);
      base_addr = 16'($urandom); reg_mask = 8'($urandom);
      if (k < n && !aborted) begin
        if (stall_beat >= 0) rdy = !(k == stall_beat && waits < stall_len);
        else                 rdy = !($urandom_range(99) < low_pct);
      end else begin
        rdy = 1'($urandom);
      end
      mem_ready = rdy;
      #1;
      w_rf   = bus.reg_write_en;  w_dest = bus.reg_write_dest; r_data = bus.reg_write_data;
      w_mem  = bus.mem_req && bus.mem_we && bus.mem_ready;
      w_addr = bus.mem_addr;      w_data = bus.mem_wdata;
      if (k < n && !aborted) begin
        a = base + 16'(k);
        chk("acc_busy", 32'(busy), 32'(1));
        chk("acc_pc_hold", 32'(pc_hold), 32'(1));
        chk("acc_done", 32'(done), 32'(0));
        chk("acc_req", 32'(bus.mem_req), 32'(1));
        chk("acc_we", 32'(bus.mem_we), 32'(!ld));
        chk("acc_addr", 32'(bus.mem_addr), 32'(a));
        chk("acc_rd_addr", 32'(bus.reg_read_addr), 32'(q[k]));
        chk("acc_xfer", 32'(xfer_count), 32'(k));
        chk("acc_wr_en", 32'(bus.reg_write_en), 32'(ld && rdy));
        if (!ld) chk("sm_wdata", 32'(bus.mem_wdata), 32'(exp_rf[q[k]]));
        if (ld && rdy) begin
          chk("lm_dest", 32'(bus.reg_write_dest), 32'(q[k]));
          chk("lm_wdata", 32'(bus.reg_write_data), 32'(exp_mem[a]));
        end
        if (rdy) begin
          if (ld) exp_rf[q[k]] = exp_mem[a];
          else    exp_mem[a]   = exp_rf[q[k]];
          k++; waits = 0;
          if (rst_at > 0 && k == rst_at && k < n) do_rst = 1;
        end else begin
          waits++;
          if (waits == TIMEOUT) aborted = 1;
        end
      end else begin
        chk("done_pulse", 32'(done), 32'(1));
        chk("done_err", 32'(err), 32'(aborted));
        chk("done_busy", 32'(busy), 32'(1));
        chk("done_req", 32'(bus.mem_req), 32'(0));
        chk("done_wr_en", 32'(bus.reg_write_en), 32'(0));
        chk("done_xfer", 32'(xfer_count), 32'(k));
        finished = 1;
      end
      @(posedge clk);
      if (w_rf)  rf[w_dest]  = r_data;
      if (w_mem) mem[w_addr] = w_data;
    end

    if (do_rst) begin
      @(negedge clk);
      rst = 1'b1; start = 1'b0; mem_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_pc_hold", 32'(pc_hold), 32'(0));
      chk("rst_xfer", 32'(xfer_count), 32'(0));
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("rst_no_req", 32'(bus.mem_req), 32'(0));
        chk("rst_no_done", 32'(done), 32'(0));
        chk("rst_no_wr", 32'(bus.reg_write_en), 32'(0));
        @(posedge clk);
      end
    end else if (!finished) begin
      vectors++; miscompares++;
      $error("FAIL op_bound: observed no done within 200 cycles, expected done");
    end else begin
      @(negedge clk);
      start = 1'b0; mem_ready = 1'b0;
      #1;
      chk("post_busy", 32'(busy), 32'(0));
      chk("post_done", 32'(done), 32'(0));
      chk("post_err", 32'(err), 32'(0));
      chk("post_xfer", 32'(xfer_count), 32'(k));
    end

    for (int i = 0; i < 8; i++) chk($sformatf("rf_R%0d", i), 32'(rf[i]), 32'(exp_rf[i]));
    for (int i = 0; i < n; i++) begin
      a = base + 16'(i);
      chk("mem_word", 32'(mem[a]), 32'(exp_mem[a]));
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; start = 1'b0; is_load = 1'b0; base_addr = '0; reg_mask = '0; mem_ready = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'($urandom); exp_mem[i] = mem[i];
    end
    for (int i = 0; i < 8; i++) begin
      rf[i] = 16'($urandom); exp_rf[i] = rf[i];
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_pc_hold", 32'(pc_hold), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_err", 32'(err), 32'(0));
    chk("reset_req", 32'(bus.mem_req), 32'(0));
    chk("reset_wr_en", 32'(bus.reg_write_en), 32'(0));
    chk("reset_xfer", 32'(xfer_count), 32'(0));
    rst = 1'b0;

    run_op(1'b1, 16'h0100, 8'b0000_0101, 0, -1, 0, -1);
    run_op(1'b0, 16'hFFFE, 8'hFF, 0, -1, 0, -1);
    run_op(1'b1, 16'h2000, 8'b1001_0110, 0, 1, 3, -1);
    run_op(1'b1, 16'h3000, 8'b0000_1100, 100, -1, 0, -1);
    run_op(1'b0, 16'h4000, 8'h00, 0, -1, 0, -1);
    run_op(1'b1, 16'h5000, 8'b1010_0011, 0, -1, 0, 1);
    run_op(1'b1, 16'hFFFF, 8'h80, 0, -1, 0, -1);
    for (int t = 0; t < 40; t++) begin
      run_op(1'($urandom), 16'($urandom), ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom),
             25, -1, 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
